mac_accum_pipe: RTL

Parametrised pipelined multiply-accumulate unit with configurable operand/accumulator widths, signedness, multiplier pipeline depth and overflow policy. Samples carry valid/first/last tags down the pipeline, so dot products of arbitrary length are framed without stalling. The block feeds filter and correlator datapaths that need a framed, flagged MAC result instead of a free-running accumulator.

---
 rtl/mac_accum_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mac_accum_pipe.sv
// Pipelined multiply-accumulate with valid/first/last framing, selectable signedness,
// multiplier depth and wrap/saturate overflow handling.
module mac_accum_pipe #(
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned B_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH   = 20,
  parameter bit          SIGNED      = 1'b0,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned MULT_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_valid,
  output logic                 overflow
);

  localparam int unsigned P_W    = A_WIDTH + B_WIDTH;
  localparam int unsigned MSB    = ACC_WIDTH - 1;
  localparam int unsigned LAST   = MULT_STAGES - 1;
  localparam int          STAGES = int'(MULT_STAGES);
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < P_W) begin : g_bad_acc_width
    $error("mac_accum_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end
  if (MULT_STAGES < 1 || MULT_STAGES > 3) begin : g_bad_stages
    $error("mac_accum_pipe: MULT_STAGES must be in 1..3");
  end

  logic                 in_v_q, in_f_q, in_l_q;
  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic [P_W-1:0]       prod_u;
  logic signed [P_W-1:0] prod_s;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] p_q [MULT_STAGES];
  logic [MULT_STAGES-1:0] v_q, f_q, l_q;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] tail_p;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_hit;
  logic                 ovf_next;

  // Full-precision product of the registered operands, extended to accumulator width.
  always_comb begin
    prod_u = P_W'(a_q) * P_W'(b_q);
    prod_s = P_W'($signed(a_q)) * P_W'($signed(b_q));
    if (SIGNED) prod_ext = ACC_WIDTH'(prod_s);
    else        prod_ext = ACC_WIDTH'(prod_u);
  end

  // Operand and product data registers carry no reset; the tags qualify them.
  always_ff @(posedge clk) begin
    a_q    <= a;
    b_q    <= b;
    p_q[0] <= prod_ext;
    for (int i = 1; i < STAGES; i++) p_q[i] <= p_q[i-1];
  end

  // Accumulate or load; overflow judged on the one-bit-wider sum.
  always_comb begin
    tail_p   = p_q[LAST];
    sum      = {1'b0, acc} + {1'b0, tail_p};
    acc_next = sum[ACC_WIDTH-1:0];
    ovf_hit  = 1'b0;
    ovf_next = overflow;
    if (f_q[LAST]) begin
      acc_next = tail_p;
      ovf_next = 1'b0;
    end else begin
      if (SIGNED) ovf_hit = (acc[MSB] == tail_p[MSB]) && (sum[MSB] != acc[MSB]);
      else        ovf_hit = sum[ACC_WIDTH];
      ovf_next = overflow | ovf_hit;
      if (ovf_hit && SATURATE) begin
        if (!SIGNED)      acc_next = '1;
        else if (acc[MSB]) acc_next = SMIN;
        else              acc_next = SMAX;
      end
    end
  end

  // Tag pipeline and accumulator state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_v_q    <= 1'b0;
      in_f_q    <= 1'b0;
      in_l_q    <= 1'b0;
      v_q       <= '0;
      f_q       <= '0;
      l_q       <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      in_v_q <= in_valid;
      in_f_q <= in_valid & in_first;
      in_l_q <= in_valid & in_last;
      v_q[0] <= in_v_q;
      f_q[0] <= in_f_q;
      l_q[0] <= in_l_q;
      for (int i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
      acc_valid <= 1'b0;
      if (v_q[LAST]) begin
        acc       <= acc_next;
        overflow  <= ovf_next;
        acc_valid <= l_q[LAST];
      end
    end
  end

endmodule
